matrix_multiply_seq: RTL and testbench

Parametrised, sequential N×N unsigned matrix multiplier that computes R = A × B with one multiply-accumulate per clock. It accepts two flat operand vectors on a start/busy/done handshake. It is the configurable successor to the fixed 10×10 single-bit multiplier and sits between the UART receive/unpack stage and the UART transmit/pack stage. The result port holds the last completed product and changes only on completion.

---
 rtl/matrix_multiply_seq.sv | 105 ++++++++++
 tb/tb_matrix_multiply_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_multiply_seq.sv
// matrix_multiply_seq: sequential NxN unsigned matrix multiply, one MAC per clock.
// Define MATMUL_SATURATE_EN to saturate result elements instead of wrapping them.
module matrix_multiply_seq #(
    parameter int N  = 10,
    parameter int DW = 1,
    parameter int RW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N*N*DW-1:0] matrixA,
    input  logic [N*N*DW-1:0] matrixB,
    output logic              busy,
    output logic              done,
    output logic [N*N*RW-1:0] result
);
    localparam int CW = $clog2(N);
    localparam int AW = 2*DW + CW;
    localparam int XW = AW > RW ? AW : RW;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              r_state;
    logic [N*N*DW-1:0]   r_a, r_b;
    logic [CW-1:0]       r_r, r_c, r_k;
    logic [AW-1:0]       r_acc;
    logic [N*N*RW-1:0]   r_scr, r_result;
    logic [31:0]         w_ia, w_ib, w_ir;
    logic [2*DW-1:0]     w_prod;
    logic [AW-1:0]       w_sum;
    logic [XW-1:0]       w_ext;
    logic [RW-1:0]       w_red;
    logic                w_kl, w_cl, w_rl;
    logic [N*N*RW-1:0]   w_scr_nx;

    assign w_ia   = 32'(r_r)*N + 32'(r_k);
    assign w_ib   = 32'(r_k)*N + 32'(r_c);
    assign w_ir   = 32'(r_r)*N + 32'(r_c);
    assign w_prod = (2*DW)'(r_a[w_ia*DW +: DW]) * (2*DW)'(r_b[w_ib*DW +: DW]);
    assign w_sum  = r_acc + AW'(w_prod);
    assign w_ext  = XW'(w_sum);
`ifdef MATMUL_SATURATE_EN
    assign w_red  = w_ext > XW'({RW{1'b1}}) ? {RW{1'b1}} : w_ext[RW-1:0];
`else
    assign w_red  = w_ext[RW-1:0];
`endif
    assign w_kl   = r_k == CW'(N-1);
    assign w_cl   = r_c == CW'(N-1);
    assign w_rl   = r_r == CW'(N-1);

    // The final element is merged here so the copy to result sees it on the same edge.
    always_comb begin
        w_scr_nx = r_scr;
        w_scr_nx[w_ir*RW +: RW] = w_red;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_r      <= '0;
            r_c      <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_scr    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state <= RUN;
                    r_a     <= matrixA;
                    r_b     <= matrixB;
                    r_r     <= '0;
                    r_c     <= '0;
                    r_k     <= '0;
                    r_acc   <= '0;
                end
                RUN: if (w_kl) begin
                    r_scr <= w_scr_nx;
                    r_acc <= '0;
                    r_k   <= '0;
                    if (w_cl) begin
                        r_c <= '0;
                        if (w_rl) begin
                            r_r      <= '0;
                            r_state  <= DONE;
                            r_result <= w_scr_nx;
                        end else
                            r_r <= r_r + CW'(1);
                    end else
                        r_c <= r_c + CW'(1);
                end else begin
                    r_acc <= w_sum;
                    r_k   <= r_k + CW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = r_state == RUN;
    assign done   = r_state == DONE;
    assign result = r_result;
endmodule

// File: tb/tb_matrix_multiply_seq.sv
// tb_matrix_multiply_seq: directed checks of matrix_multiply_seq at three configurations.
module tb_matrix_multiply_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic         st10 = 1'b0, busy10, done10;
    logic [99:0]  a10 = '0, b10 = '0;
    logic [399:0] res10;
    logic         st4 = 1'b0, busy4, done4;
    logic [63:0]  a4 = '0, b4 = '0;
    logic [127:0] res4;
    logic         st2 = 1'b0, busy2, done2;
    logic [15:0]  a2 = '0, b2 = '0;
    logic [15:0]  res2;

    matrix_multiply_seq #(.N(10), .DW(1), .RW(4)) u10 (.clk(clk), .rst_n(rst_n), .start(st10),
        .matrixA(a10), .matrixB(b10), .busy(busy10), .done(done10), .result(res10));
    matrix_multiply_seq #(.N(4), .DW(4), .RW(8)) u4 (.clk(clk), .rst_n(rst_n), .start(st4),
        .matrixA(a4), .matrixB(b4), .busy(busy4), .done(done4), .result(res4));
    matrix_multiply_seq #(.N(2), .DW(4), .RW(4)) u2 (.clk(clk), .rst_n(rst_n), .start(st2),
        .matrixA(a2), .matrixB(b2), .busy(busy2), .done(done2), .result(res2));

    typedef struct {
        logic [15:0] a, b, ew, es;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [399:0] act, input logic [399:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // lat counts edges after the accepting edge until done is seen (N^3 expected).
    task automatic run2(input logic [15:0] a, input logic [15:0] b, output int lat);
        a2 = a; b2 = b; st2 = 1'b1;
        step();
        st2 = 1'b0; a2 = '0; b2 = '0;
        lat = 0;
        while (!done2 && lat < 200) begin step(); lat++; end
    endtask

    task automatic run10(output int lat, output int bc, output bit stable);
        logic [399:0] prev;
        prev = res10; bc = 0; stable = 1'b1;
        st10 = 1'b1;
        step();
        st10 = 1'b0; a10 = '0; b10 = '0;
        lat = 0;
        while (!done10 && lat < 2000) begin
            if (busy10) bc++;
            if (res10 !== prev) stable = 1'b0;
            step();
            lat++;
        end
    endtask

    initial begin
        int lat, bc, nd, first, second;
        bit stable;
        logic [127:0] e4;
        logic [399:0] p4;
        tbl[0] = '{16'h1001, 16'h4321, 16'h4321, 16'h4321};
        tbl[1] = '{16'h4321, 16'h8765, 16'h2B63, 16'hFFFF};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 16'h2222, 16'hFFFF};
        tbl[3] = '{16'h3002, 16'h4321, 16'hC942, 16'hC942};
        tbl[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[5] = '{16'h1111, 16'h1087, 16'h9797, 16'h9797};

        repeat (3) step();
        chk("reset res10", res10, '0);
        chk("reset busy10", busy10, 0);
        chk("reset done10", done10, 0);
        chk("reset res4", res4, '0);
        chk("reset res2", res2, '0);
        chk("reset busy2/done2", {busy2, done2}, 0);
        rst_n = 1'b1;
        step();

        a10 = '1; b10 = '1;
        run10(lat, bc, stable);
        chk("ones latency", lat, 1000);
        chk("ones busy cycles", bc, 1000);
        chk("ones result", res10, {100{4'hA}});
        chk("ones result stable in RUN", stable, 1);
        step();
        chk("ones done one cycle", {busy10, done10}, 0);

        e4 = '0;
        for (int i = 0; i < 16; i++) begin
            a4[i*4 +: 4] = (i / 4 == i % 4) ? 4'd1 : 4'd0;
            b4[i*4 +: 4] = 4'(i);
            e4[i*8 +: 8] = 8'(i);
        end
        st4 = 1'b1;
        step();
        st4 = 1'b0; a4 = '0; b4 = '0;
        lat = 0; stable = 1'b1; p4 = res4;
        while (!done4 && lat < 200) begin
            if (res4 !== p4[127:0]) stable = 1'b0;
            step();
            lat++;
        end
        chk("ident latency", lat, 64);
        chk("ident result", res4, e4);
        chk("ident stable in RUN", stable, 1);

        for (int i = 0; i < 6; i++) begin
            run2(tbl[i].a, tbl[i].b, lat);
            chk($sformatf("vec%0d latency", i), lat, 8);
`ifdef MATMUL_SATURATE_EN
            chk($sformatf("vec%0d result", i), res2, tbl[i].es);
`else
            chk($sformatf("vec%0d result", i), res2, tbl[i].ew);
`endif
            step();
        end

        a2 = 16'h1111; b2 = 16'h1087; st2 = 1'b1;
        step();
        a2 = 16'h3002; b2 = 16'h4321;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            st2 = (i == 3) || done2;
            if (done2) nd++;
            step();
        end
        st2 = 1'b0;
        chk("hs single done", nd, 1);
        chk("hs result", res2, 16'h9797);
        chk("hs idle after", busy2, 0);

        a2 = 16'h3002; b2 = 16'h4321; st2 = 1'b1;
        step();
        lat = 0; first = -1; second = -1;
        while (second < 0 && lat < 100) begin
            if (done2) begin
                if (first < 0) first = lat;
                else second = lat;
            end
            step();
            lat++;
        end
        st2 = 1'b0;
        chk("held first done", first, 8);
        chk("held spacing", second - first, 10);
        chk("held result", res2, 16'hC942);
        repeat (3) step();

        a10 = '1; b10 = '1; st10 = 1'b1;
        step();
        st10 = 1'b0;
        repeat (499) step();
        chk("midrun busy before reset", busy10, 1);
        rst_n = 1'b0; st10 = 1'b1;
        step();
        st10 = 1'b0;
        rst_n = 1'b1;
        chk("midrun res after reset", res10, '0);
        chk("midrun busy/done after reset", {busy10, done10}, 0);
        step();
        chk("midrun start ignored in reset", busy10, 0);
        nd = 0;
        for (int i = 0; i < 1100; i++) begin
            if (done10 || busy10) nd++;
            step();
        end
        chk("midrun no activity", nd, 0);
        a10 = '1; b10 = '1;
        run10(lat, bc, stable);
        chk("fresh latency", lat, 1000);
        chk("fresh result", res10, {100{4'hA}});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
